param_ram: RTL and testbench

Parametrised synchronous single-clock RAM with independent write and read ports, a registered read, and a built-in clear sequencer. It succeeds the fixed 4x16 RAM in the digital-system lab set. It adds these behaviours:

- generic width and depth
- selectable read-during-write mode
- automatic memory clear after reset and on request
- flagged out-of-range accesses

It sits as the storage element behind lab datapaths and the planned FIFO/register-file blocks.

---
 rtl/param_ram_pkg.sv | 20 ++
 rtl/param_ram_init_seq.sv | 60 ++++++
 rtl/param_ram.sv | 139 +++++++++++++
 tb/tb_param_ram.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_ram_pkg.sv
// param_ram shared types and constants.
// Clear-sequencer state and read-during-write mode encodings.
package param_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic logic in_range(
    input int unsigned addr,
    input int unsigned depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/param_ram_init_seq.sv
// param_ram clear sequencer: state register and clear pointer.
// Sweeps every word once after reset or on request.
module param_ram_init_seq
  import param_ram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_req,
  output logic              o_init_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    unique case (r_state)
      ST_INIT: begin
        if (r_ptr == LAST) begin
          w_state_nx = ST_READY;
          w_ptr_nx   = '0;
        end else begin
          w_ptr_nx = r_ptr + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (i_init_req) begin
          w_state_nx = ST_INIT;
          w_ptr_nx   = '0;
        end
      end
    endcase
  end

  assign o_init_busy = (r_state == ST_INIT);
  assign o_clr_we    = (r_state == ST_INIT);
  assign o_clr_addr  = r_ptr;

endmodule

// File: rtl/param_ram.sv
// param_ram: parametrised single-clock RAM, registered read,
// selectable read-during-write and a self-clearing sequencer.
module param_ram
  import param_ram_pkg::*;
#(
  parameter int              DATA_W    = 4,
  parameter int              ADDR_W    = 4,
  parameter int              DEPTH     = 2**ADDR_W,
  parameter int              RDW_MODE  = RDW_OLD,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              init_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              init_busy
);

  localparam int IDX_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic NEW_FIRST =
    (RDW_MODE == RDW_NEW);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_usr_we;
  logic              w_usr_re;
  logic              w_rdw_hit;

  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_word;

  logic              w_rd_oob;
  logic              w_rd_new;
  logic              w_rd_mem;
  logic [DATA_W-1:0] w_rd_data_nx;
  logic              w_rd_valid_nx;
  logic              w_rd_err_nx;

  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_err;

  param_ram_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_init_req  (init_req),
    .o_init_busy (w_busy),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr)
  );

  // init_req wins over any access in the same cycle
  assign w_wr_ok  = in_range(32'(wr_addr), DEPTH);
  assign w_rd_ok  = in_range(32'(rd_addr), DEPTH);
  assign w_usr_we = wr_en & w_wr_ok
                  & ~w_busy & ~init_req;
  assign w_usr_re = rd_en & ~w_busy & ~init_req;
  assign w_rdw_hit = w_usr_we
                   & (wr_addr == rd_addr);

  assign w_mem_we    = w_clr_we | w_usr_we;
  assign w_mem_waddr = w_clr_we
                     ? w_clr_addr[IDX_W-1:0]
                     : wr_addr[IDX_W-1:0];
  assign w_mem_wdata = w_clr_we ? CLEAR_VAL : wr_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_rd_word = r_mem[rd_addr[IDX_W-1:0]];

  assign w_rd_oob = w_usr_re & ~w_rd_ok;
  assign w_rd_new = w_usr_re & w_rd_ok
                  & w_rdw_hit & NEW_FIRST;
  assign w_rd_mem = w_usr_re & w_rd_ok
                  & ~(w_rdw_hit & NEW_FIRST);

  always_comb begin
    w_rd_data_nx  = r_rd_data;
    w_rd_valid_nx = 1'b0;
    w_rd_err_nx   = 1'b0;
    unique case (1'b1)
      w_rd_oob: begin
        w_rd_data_nx  = '0;
        w_rd_valid_nx = 1'b1;
        w_rd_err_nx   = 1'b1;
      end
      w_rd_new: begin
        w_rd_data_nx  = wr_data;
        w_rd_valid_nx = 1'b1;
      end
      w_rd_mem: begin
        w_rd_data_nx  = w_rd_word;
        w_rd_valid_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_data  <= w_rd_data_nx;
      r_rd_valid <= w_rd_valid_nx;
      r_rd_err   <= w_rd_err_nx;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_err;
  assign init_busy = w_busy;

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: three param_ram variants (old-data, new-data,
// DEPTH=12) on shared stimulus against a behavioural model.
module tb_param_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       init_req = 1'b0;

  logic [2:0][3:0] rd_data;
  logic [2:0]      rd_valid;
  logic [2:0]      rd_err;
  logic [2:0]      init_busy;

  int  D [3] = '{16, 16, 12};
  bit  M [3] = '{1'b0, 1'b1, 1'b0};

  logic [3:0] mem [3][16];
  int         busy_left [3];
  logic [3:0] e_data [3];
  bit         e_valid [3];
  bit         e_err [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_ram #(.RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .init_req(init_req),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .rd_err(rd_err[0]), .init_busy(init_busy[0])
  );

  param_ram #(.RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .init_req(init_req),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .rd_err(rd_err[1]), .init_busy(init_busy[1])
  );

  param_ram #(.DEPTH(12), .RDW_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .init_req(init_req),
    .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
    .rd_err(rd_err[2]), .init_busy(init_busy[2])
  );

  task automatic model_reset;
    for (int k = 0; k < 3; k++) begin
      busy_left[k] = D[k];
      e_data[k]  = '0;
      e_valid[k] = 1'b0;
      e_err[k]   = 1'b0;
      for (int a = 0; a < 16; a++) mem[k][a] = '0;
    end
  endtask

  // A clear empties the whole memory at once: nothing can read it
  // until the busy window is over, so the sweep order is invisible.
  task automatic model_step;
    for (int k = 0; k < 3; k++) begin
      if (busy_left[k] > 0) begin
        busy_left[k]--;
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
      end else if (init_req) begin
        busy_left[k] = D[k];
        for (int a = 0; a < 16; a++) mem[k][a] = '0;
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
      end else begin
        if (rd_en) begin
          e_valid[k] = 1'b1;
          if (int'(rd_addr) < D[k]) begin
            e_err[k] = 1'b0;
            if (M[k] && wr_en && wr_addr == rd_addr)
              e_data[k] = wr_data;
            else
              e_data[k] = mem[k][rd_addr];
          end else begin
            e_err[k]  = 1'b1;
            e_data[k] = '0;
          end
        end else begin
          e_valid[k] = 1'b0;
          e_err[k]   = 1'b0;
        end
        if (wr_en && int'(wr_addr) < D[k])
          mem[k][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0;
    rd_en = 1'b0;
    init_req = 1'b0;
  endtask

  task automatic wait_ready;
    int i;
    i = 0;
    idle();
    while (init_busy !== 3'b000 && i < 40) begin
      tick();
      i++;
    end
    n_tests++;
    if (init_busy !== 3'b000) begin
      n_fail++;
      $display("FAIL wait_ready: init_busy=%b after %0d cycles, need 000",
               init_busy, i);
    end
  endtask

  task automatic test_reset;
    int cnt [3];
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'h0 || rd_valid[k] !== 1'b0 ||
          rd_err[k] !== 1'b0 || init_busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_vals[%0d]: d=%h v=%b e=%b b=%b, need 0 0 0 1",
                 k, rd_data[k], rd_valid[k], rd_err[k], init_busy[k]);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cnt[k] = int'(init_busy[k]);
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd9;
        rd_en = 1'b1; rd_addr = 4'd3;
      end else begin
        idle();
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        cnt[k] += int'(init_busy[k]);
        n_tests++;
        if (rd_valid[k] !== e_valid[k] ||
            init_busy[k] !== (busy_left[k] > 0)) begin
          n_fail++;
          $display("FAIL busy_access[%0d] c=%0d: v=%b b=%b, need %b %b",
                   k, c, rd_valid[k], init_busy[k], e_valid[k],
                   busy_left[k] > 0);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (cnt[k] != D[k]) begin
        n_fail++;
        $display("FAIL busy_len[%0d]: %0d cycles, need %0d",
                 k, cnt[k], D[k]);
      end
    end
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'h0 || rd_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL cleared_read[%0d]: d=%h v=%b, need 0 1",
                 k, rd_data[k], rd_valid[k]);
      end
    end
  endtask

  task automatic test_basic;
    wait_ready();
    wr_en = 1'b1; wr_addr = 4'b1010; wr_data = 4'b0011;
    tick();
    wr_addr = 4'b0111; wr_data = 4'b1001;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 4'b1010;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'b0011 || rd_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_rd1[%0d]: d=%b v=%b, need 0011 1",
                 k, rd_data[k], rd_valid[k]);
      end
    end
    rd_addr = 4'b0111;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'b1001 || rd_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_rd2[%0d]: d=%b v=%b, need 1001 1",
                 k, rd_data[k], rd_valid[k]);
      end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'b1001 || rd_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: d=%b v=%b, need 1001 0",
                 k, rd_data[k], rd_valid[k]);
      end
    end
  endtask

  task automatic test_rdw;
    logic [3:0] want;
    wait_ready();
    wr_en = 1'b1; wr_addr = 4'b0101; wr_data = 4'b0110;
    tick();
    wr_data = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'b0101;
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      want = M[k] ? 4'b1111 : 4'b0110;
      n_tests++;
      if (rd_data[k] !== want || rd_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL rdw_same[%0d]: d=%b v=%b, need %b 1",
                 k, rd_data[k], rd_valid[k], want);
      end
    end
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'b1111 || rd_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL rdw_after[%0d]: d=%b v=%b, need 1111 1",
                 k, rd_data[k], rd_valid[k]);
      end
    end
  endtask

  task automatic test_oob;
    wait_ready();
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 4'b1010;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd13;
    tick();
    n_tests++;
    if (rd_data[2] !== 4'h0 || rd_valid[2] !== 1'b1 ||
        rd_err[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_rd13: d=%b v=%b e=%b, need 0000 1 1",
               rd_data[2], rd_valid[2], rd_err[2]);
    end
    n_tests++;
    if (rd_data[0] !== 4'b1010 || rd_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rd13: d=%b e=%b, need 1010 0",
               rd_data[0], rd_err[0]);
    end
    rd_addr = 4'd11;
    tick();
    idle();
    n_tests++;
    if (rd_valid[2] !== 1'b1 || rd_err[2] !== 1'b0 ||
        rd_data[2] !== e_data[2]) begin
      n_fail++;
      $display("FAIL oob_rd11: d=%b v=%b e=%b, need %b 1 0",
               rd_data[2], rd_valid[2], rd_err[2], e_data[2]);
    end
    tick();
    n_tests++;
    if (rd_err[2] !== 1'b0 || rd_valid[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_pulse: v=%b e=%b, need 0 0",
               rd_valid[2], rd_err[2]);
    end
  endtask

  task automatic test_init_req;
    int cnt [3];
    wait_ready();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'b0101;
    tick();
    wr_addr = 4'd4; wr_data = 4'b0111;
    rd_en = 1'b1; rd_addr = 4'd2;
    init_req = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = int'(init_busy[k]);
      n_tests++;
      if (rd_valid[k] !== 1'b0 || init_busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL init_req_edge[%0d]: v=%b b=%b, need 0 1",
                 k, rd_valid[k], init_busy[k]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int k = 0; k < 3; k++) cnt[k] += int'(init_busy[k]);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (cnt[k] != D[k]) begin
        n_fail++;
        $display("FAIL init_req_len[%0d]: %0d cycles, need %0d",
                 k, cnt[k], D[k]);
      end
    end
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    rd_addr = 4'd4;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'h0 || rd_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL init_cleared2[%0d]: d=%b v=%b, need 0000 1",
                 k, rd_data[k], rd_valid[k]);
      end
    end
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL init_ignored_wr[%0d]: d=%b, need 0000",
                 k, rd_data[k]);
      end
    end
  endtask

  task automatic test_async_reset;
    int cnt [3];
    wait_ready();
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 4'b1100;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd6;
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_data[k] !== 4'h0 || rd_valid[k] !== 1'b0 ||
          init_busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL arst_access[%0d]: d=%h v=%b b=%b, need 0 0 1",
                 k, rd_data[k], rd_valid[k], init_busy[k]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_valid[k] !== 1'b0 || init_busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL arst_clear[%0d]: v=%b b=%b, need 0 1",
                 k, rd_valid[k], init_busy[k]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cnt[k] = int'(init_busy[k]);
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int k = 0; k < 3; k++) cnt[k] += int'(init_busy[k]);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (cnt[k] != D[k]) begin
        n_fail++;
        $display("FAIL arst_len[%0d]: %0d cycles, need %0d",
                 k, cnt[k], D[k]);
      end
    end
  endtask

  task automatic test_random;
    wait_ready();
    for (int c = 0; c < 600; c++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 4'($urandom_range(0, 15));
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_addr  = ($urandom_range(0, 3) == 0)
               ? wr_addr : 4'($urandom_range(0, 15));
      init_req = ($urandom_range(0, 59) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (rd_data[k] !== e_data[k] || rd_valid[k] !== e_valid[k] ||
            rd_err[k] !== e_err[k] ||
            init_busy[k] !== (busy_left[k] > 0)) begin
          n_fail++;
          $display("FAIL random[%0d] c=%0d: d=%h v=%b e=%b b=%b, need %h %b %b %b",
                   k, c, rd_data[k], rd_valid[k], rd_err[k], init_busy[k],
                   e_data[k], e_valid[k], e_err[k], busy_left[k] > 0);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rdw();
    test_oob();
    test_init_req();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
